byte_access_controller: RTL and testbench

- Responder side of the byte-serial memory path: serves byte, halfword and word load/store requests from the processor against a 32-bit-wide single-port word RAM.
- Sub-word stores are performed as read-modify-write.
- Byte ordering is big-endian: byte offset 0 maps to bits [31:24], matching the processor's data memory view.
- Sits between the load/store stage and the word RAM macro.

---
 rtl/byte_access_pkg.sv | 55 +++++
 rtl/byte_access_lane_align.sv | 39 +++
 rtl/byte_access_controller.sv | 130 +++++++++++++
 tb/tb_byte_access_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_access_pkg.sv
// ------------------------------------------------------------------
// byte_access_pkg : size/state encodings and big-endian lane helpers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package byte_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WT       = 3'd2,
    ST_WR       = 3'd3,
    ST_RESP     = 3'd4,
    ST_ERR_RESP = 3'd5
  } state_e;

  // Right-shift that brings the addressed lane down to bit 0 (offset 0 is the MSB lane).
  function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_shift = {~offset, 3'b000};
      SZ_HALF: lane_shift = {~offset[1], 4'b0000};
      default: lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = LANE_MASK_BYTE;
      SZ_HALF: lane_mask = LANE_MASK_HALF;
      default: lane_mask = LANE_MASK_WORD;
    endcase
  endfunction

  function automatic logic bad_request(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      SZ_BYTE: bad_request = 1'b0;
      SZ_HALF: bad_request = offset[0];
      SZ_WORD: bad_request = (offset != 2'b00);
      default: bad_request = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_access_lane_align.sv
// ------------------------------------------------------------------
// lane_align : big-endian load extract/extend and sub-word store merge
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lane_align
  import byte_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shift;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    shift = lane_shift(offset_i, size_i);
    lane  = word_i >> shift;
    mask  = lane_mask(size_i) << shift;

    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
      SZ_HALF: load_o = {{16{signed_i & lane[15]}}, lane[15:0]};
      default: load_o = word_i;
    endcase

    merge_o = (word_i & ~mask) | ((wdata_i << shift) & mask);
  end

endmodule

`default_nettype wire

// File: rtl/byte_access_controller.sv
// ------------------------------------------------------------------
// byte_access_controller : byte/half/word load-store responder over a word RAM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module byte_access_controller
  import byte_access_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  generate
    if (RAM_LAT != 1) begin : g_ram_lat_check
      $error("byte_access_controller: RAM_LAT must be 1");
    end
  endgenerate

  state_e              state_q, state_d;
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [31:0]         load_word;
  logic [31:0]         merge_word;
  logic                accept;
  logic                addr_unused;

  // Upper address bits are deliberately dropped so accesses wrap modulo RAM size.
  assign addr_unused = ^req_addr_i[31:ADDR_W+2];

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  lane_align u_lane_align (
    .word_i   (ram_rdata_i),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (bad_request(req_addr_i[1:0], req_size_i))
            state_d = ST_ERR_RESP;
          else if (req_write_i && (req_size_i == SZ_WORD))
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD:       state_d = ST_WT;
      ST_WT:       state_d = write_q ? ST_WR : ST_RESP;
      ST_WR:       state_d = ST_RESP;
      ST_RESP,
      ST_ERR_RESP: if (resp_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else if (accept) begin
      write_q  <= req_write_i;
      size_q   <= req_size_i;
      signed_q <= req_signed_i;
      off_q    <= req_addr_i[1:0];
      addr_q   <= req_addr_i[ADDR_W+1:2];
      wdata_q  <= req_wdata_i;
      rdata_q  <= 32'd0;
    end else if (state_q == ST_WT) begin
      // wdata_q doubles as the merged write word for sub-word stores.
      if (write_q) wdata_q <= merge_word;
      else         rdata_q <= load_word;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = (state_q == ST_RESP) || (state_q == ST_ERR_RESP);
    resp_err_o   = (state_q == ST_ERR_RESP);
    ram_we_o     = (state_q == ST_WR);
  end

  assign ram_addr_o   = addr_q;
  assign ram_wdata_o  = wdata_q;
  assign resp_rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_access_controller.sv
// ------------------------------------------------------------------
// tb_byte_access_controller : scoreboard bench with a byte-array memory reference
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_byte_access_controller;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata, ram_rdata;

  byte_access_controller #(.ADDR_W(ADDR_W), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .ram_addr_o(ram_addr),
    .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM macro model, read-first, one-cycle read latency.
  logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: 32'd0};
  int we_count = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_count <= we_count + 1;
    end
  end

  // Reference: memory as a flat big-endian byte array (2^ADDR_W words = 2^16 bytes).
  logic [7:0] ref_b [0:(4<<ADDR_W)-1] = '{default: 8'd0};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'(a & 32'h0000_FFFF);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_b[bidx(a)], ref_b[bidx(a+1)], ref_b[bidx(a+2)], ref_b[bidx(a+3)]};
  endfunction

  function automatic exp_t ref_exec(input logic w, input logic [1:0] sz, input logic sg,
                                    input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    logic [31:0] v;
    n = 1 << sz;
    e.rdata = 32'd0;
    e.err   = (sz == 2'd3) || ((a % 4) % n != 0);
    e.we    = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (w) begin
      for (int i = 0; i < n; i++) ref_b[bidx(a+i)] = 8'(d >> (8*(n-1-i)));
      e.we  = 1;
      e.lat = (n == 4) ? 2 : 4;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[bidx(a+i)]);
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
      e.lat   = 3;
    end
    return e;
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int waited = 0;
    @(posedge clk); #1;
    while (!req_ready && waited < 200) begin @(posedge clk); #1; waited++; end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(ref_exec(w, sz, sg, a, d));
  endtask

  task automatic wait_idle();
    int waited = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && req_ready) && waited < 300) begin @(negedge clk); waited++; end
    if (sb.size() != 0 || !req_ready)
      check("drain_timeout_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      resp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops an expectation for each response and checks latency, data and stability.
  initial begin
    int acc_cyc = 0, we_acc = 0;
    bit in_resp = 1'b0;
    logic [31:0] snap_rdata;
    logic snap_err;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          acc_cyc = cyc + 1;
          we_acc  = we_count;
        end
        if (resp_valid) begin
          if (!in_resp) begin
            in_resp = 1'b1;
            snap_rdata = resp_rdata;
            snap_err   = resp_err;
            if (sb.size() == 0) check("resp_with_empty_scoreboard", {31'd0, resp_valid}, 32'd0);
            else check("latency", 32'(cyc - acc_cyc + 1), 32'(sb[0].lat));
          end else begin
            check("stall_rdata", resp_rdata, snap_rdata);
            check("stall_err", {31'd0, resp_err}, {31'd0, snap_err});
          end
          check("busy_req_ready", {31'd0, req_ready}, 32'd0);
          check("resp_ram_we", {31'd0, ram_we}, 32'd0);
          if (resp_ready) begin
            in_resp = 1'b0;
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("resp_rdata", resp_rdata, e.rdata);
              check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
              check("we_pulses", 32'(we_count - we_acc), 32'(e.we));
            end
          end
        end
      end
    end
  end

  initial begin
    int saved_we;
    logic [31:0] a;
    logic [1:0] sz;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #22;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    wait_idle();
    check("mem4_word_store", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
    wait_idle();
    check("mem4_byte_merge", mem[4], 32'h1122AA44);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'd0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000BEEF);
    wait_idle();
    check("mem4_after_errors", mem[4], 32'h80FF7F01);

    // Stall a load response; a request offered meanwhile must be ignored.
    stall = 1'b1;
    @(posedge clk);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b0;
    stall = 1'b0;
    wait_idle();
    check("mem16_ignored_req", mem[16], 32'd0);

    // Reset during WT of a byte store: the write must never happen.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h55667788);
    wait_idle();
    saved_we = we_count;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h00000099;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    check("abort_ram_wdata", ram_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_we_count", 32'(we_count), 32'(saved_we));
    check("abort_mem8", mem[8], 32'h55667788);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 16);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    wait_idle();
    for (int w = 0; w < 16; w++)
      check("final_mem", mem[w], ref_word(32'(w * 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
